// File: rtl/haar_h_pair_split.sv
// One-level horizontal Haar split on column pairs. Each row leaves as WIDTH/2
// low-pass tokens followed by the WIDTH/2 high-pass tokens held in hi_buf.
module haar_h_pair_split #(
  parameter int WIDTH = 512,
  parameter int IDX_W = 8
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic signed [15:0] In1_DATA,
  input  logic               In1_SEND,
  output logic               In1_ACK,
  input  logic [15:0]        In1_COUNT,
  output logic signed [15:0] Out1_DATA,
  output logic               Out1_SEND,
  input  logic               Out1_RDY,
  input  logic               Out1_ACK,
  output logic [15:0]        Out1_COUNT
);
  localparam int HALF = WIDTH / 2;
  localparam int AW   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(HALF - 1);

  typedef enum logic [1:0] {S_A, S_B, S_LO, S_FLUSH} state_t;

  state_t                  state_q, state_d;
  logic signed [15:0]      a_q, a_d;
  logic signed [15:0]      lo_q, lo_d;
  logic [IDX_W-1:0]        pair_idx_q, pair_idx_d;
  logic [IDX_W-1:0]        flush_idx_q, flush_idx_d;
  logic signed [15:0]      hi_buf [HALF];
  logic                    hi_we;
  logic signed [15:0]      hi_wdata;
  logic signed [15:0]      hi_rdata;
  logic                    unused_ok;

  // 17-bit sum/difference then floor halving; the result always fits in 16 bits.
  function automatic logic signed [15:0] haar_lo(input logic signed [15:0] a,
                                                 input logic signed [15:0] b);
    logic signed [16:0] s;
    logic signed [16:0] h;
    s = {a[15], a} + {b[15], b};
    h = s >>> 1;
    return h[15:0];
  endfunction

  function automatic logic signed [15:0] haar_hi(input logic signed [15:0] a,
                                                 input logic signed [15:0] b);
    logic signed [16:0] d;
    logic signed [16:0] h;
    d = {a[15], a} - {b[15], b};
    h = d >>> 1;
    return h[15:0];
  endfunction

  assign Out1_COUNT = 16'h0001;
  assign unused_ok  = ^{In1_COUNT, Out1_ACK};
  assign hi_rdata   = hi_buf[flush_idx_q[AW-1:0]];
  assign hi_wdata   = haar_hi(a_q, In1_DATA);

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    lo_d        = lo_q;
    pair_idx_d  = pair_idx_q;
    flush_idx_d = flush_idx_q;
    hi_we       = 1'b0;
    In1_ACK     = 1'b0;
    Out1_SEND   = 1'b0;
    Out1_DATA   = lo_q;
    case (state_q)
      S_A: begin
        In1_ACK = In1_SEND & ~RESET;
        if (In1_ACK) begin
          a_d     = In1_DATA;
          state_d = S_B;
        end
      end
      S_B: begin
        In1_ACK = In1_SEND & ~RESET;
        if (In1_ACK) begin
          lo_d    = haar_lo(a_q, In1_DATA);
          hi_we   = 1'b1;
          state_d = S_LO;
        end
      end
      S_LO: begin
        Out1_SEND = Out1_RDY & ~RESET;
        if (Out1_SEND) begin
          if (pair_idx_q == LAST) begin
            flush_idx_d = '0;
            state_d     = S_FLUSH;
          end else begin
            pair_idx_d = pair_idx_q + IDX_W'(1);
            state_d    = S_A;
          end
        end
      end
      S_FLUSH: begin
        Out1_DATA = hi_rdata;
        Out1_SEND = Out1_RDY & ~RESET;
        if (Out1_SEND) begin
          if (flush_idx_q == LAST) begin
            pair_idx_d = '0;
            state_d    = S_A;
          end else begin
            flush_idx_d = flush_idx_q + IDX_W'(1);
          end
        end
      end
      default: state_d = S_A;
    endcase
  end

  // Pair/row control registers
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q     <= S_A;
      a_q         <= '0;
      lo_q        <= '0;
      pair_idx_q  <= '0;
      flush_idx_q <= '0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      lo_q        <= lo_d;
      pair_idx_q  <= pair_idx_d;
      flush_idx_q <= flush_idx_d;
    end
  end

  // High-pass row buffer: contents survive reset, only the indices are cleared
  always_ff @(posedge CLK) begin
    if (hi_we) begin
      hi_buf[pair_idx_q[AW-1:0]] <= hi_wdata;
    end
  end

endmodule
